// File: rtl/register_file_bypass_if.sv
// Register file port bundle: two read ports, writeback port, issue port and
// the pending-scoreboard status outputs.
interface register_file_bypass_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] readRegister1;
  logic [ADDR_WIDTH-1:0] readRegister2;
  logic [DATA_WIDTH-1:0] readData1;
  logic [DATA_WIDTH-1:0] readData2;
  logic                  readPending1;
  logic                  readPending2;
  logic                  regWrite;
  logic [ADDR_WIDTH-1:0] writeRegister;
  logic [DATA_WIDTH-1:0] writeData;
  logic                  issueValid;
  logic [ADDR_WIDTH-1:0] issueRegister;
  logic [ADDR_WIDTH:0]   pendingCount;

  // Pipeline side: decode/writeback drive indices and data
  modport master (
    output readRegister1, readRegister2, regWrite, writeRegister, writeData,
           issueValid, issueRegister,
    input  readData1, readData2, readPending1, readPending2, pendingCount
  );

  // Register file side
  modport slave (
    input  readRegister1, readRegister2, regWrite, writeRegister, writeData,
           issueValid, issueRegister,
    output readData1, readData2, readPending1, readPending2, pendingCount
  );
endinterface

// File: rtl/register_file_bypass.sv
// MIPS-style register file: two combinational read ports, one synchronous
// write port, optional write-to-read forwarding, optional hardwired r0, and a
// per-register pending scoreboard with a registered popcount.
module register_file_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int ZERO_REG   = 1,
  parameter int BYPASS     = 1
) (
  input logic                    clk,
  input logic                    reset,
  register_file_bypass_if.slave  rf
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] regs;
  logic [DEPTH-1:0]                 pending;
  logic [DEPTH-1:0]                 pendingNext;
  logic [ADDR_WIDTH:0]              pendCnt;
  logic [ADDR_WIDTH:0]              pendCntNext;

  logic                  wrEn;
  logic                  isEn;
  logic [1:0][ADDR_WIDTH-1:0] rdAddr;
  logic [1:0][DATA_WIDTH-1:0] rdData;
  logic [1:0]                 rdPend;

  // Writes and issues aimed at the hardwired zero register are dropped here,
  // so neither the array, the forwarding path nor the scoreboard sees them.
  assign wrEn = rf.regWrite   && !((ZERO_REG != 0) && (rf.writeRegister == '0));
  assign isEn = rf.issueValid && !((ZERO_REG != 0) && (rf.issueRegister == '0));

  // Next scoreboard state: writeback clears, issue sets; issue applied last so
  // a same-edge issue+write leaves the new producer outstanding.
  always_comb begin
    pendingNext = pending;
    if (wrEn) pendingNext[rf.writeRegister] = 1'b0;
    if (isEn) pendingNext[rf.issueRegister] = 1'b1;
    pendCntNext = '0;
    for (int i = 0; i < DEPTH; i++)
      pendCntNext = pendCntNext + (ADDR_WIDTH+1)'(pendingNext[i]);
  end

  // Array, scoreboard and count update; reset overrides write and issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      regs    <= '0;
      pending <= '0;
      pendCnt <= '0;
    end else begin
      if (wrEn) regs[rf.writeRegister] <= rf.writeData;
      pending <= pendingNext;
      pendCnt <= pendCntNext;
    end
  end

  assign rdAddr = {rf.readRegister2, rf.readRegister1};

  // Read ports: array value, optionally forwarded from the in-flight write;
  // the pending bit is never forwarded and flips only at the edge.
  always_comb begin
    rdData = '0;
    rdPend = '0;
    for (int p = 0; p < 2; p++) begin
      rdData[p] = regs[rdAddr[p]];
      if ((BYPASS != 0) && wrEn && (rf.writeRegister == rdAddr[p]))
        rdData[p] = rf.writeData;
      if ((ZERO_REG != 0) && (rdAddr[p] == '0))
        rdData[p] = '0;
      rdPend[p] = pending[rdAddr[p]];
    end
  end

  assign rf.readData1    = rdData[0];
  assign rf.readData2    = rdData[1];
  assign rf.readPending1 = rdPend[0];
  assign rf.readPending2 = rdPend[1];
  assign rf.pendingCount = pendCnt;
endmodule
